// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Holds the RISC-V word constants, default reset PC and FSM encodings.
package fetch_unit_pkg;

    localparam logic [31:0] RV_NOP           = 32'h0000_0013;
    localparam logic [31:0] RV_ZERO          = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FETCH_RUN   = 1'b0,
        FETCH_FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {word, pc} pairs.
// Flush wins over push and pop in the same cycle.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output fetch_entry_t               head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;

    // Pointer and occupancy bookkeeping; pointers wrap as DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; contents are meaningless until counted, so no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads, queues
// returned words with their PCs and hands them to decode one per cycle.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fault
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]  OUT_MAX = '1;

    fetch_state_t  state;
    fetch_state_t  state_next;
    logic [31:0]   pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [CW-1:0] in_use;
    logic [CW-1:0] in_flight_next;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          run;
    logic          req_fire;
    logic          redir_ok;
    logic          redir_bad;
    logic          push;
    logic          pop;
    logic          flush;

    assign run       = (state == FETCH_RUN);
    assign redir_ok  = run && redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redir_bad = run && redirect_valid && (redirect_pc[1:0] != 2'b00);

    // Live entries: queued words plus kept responses still in flight.
    // Modular arithmetic is exact because the true value never exceeds DEPTH.
    assign in_use = count + outstanding - drop;

    // The outstanding guard keeps the counter from wrapping when repeated
    // redirects pile stale responses on top of fresh requests.
    assign imem_req_valid = run && !rst && (in_use < DEPTH_C)
                            && (outstanding != OUT_MAX);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign in_flight_next = outstanding + CW'(req_fire) - CW'(imem_resp_valid);

    assign inst_valid = run && (count != '0);
    assign inst       = inst_valid ? head.word : RV_ZERO;
    assign inst_pc    = inst_valid ? head.pc : RV_ZERO;
    assign fault      = (state == FETCH_FAULT);

    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign push       = run && !redirect_valid && imem_resp_valid && (drop == '0);
    assign flush      = !run || redirect_valid;
    assign push_entry = '{word: imem_resp_data, pc: resp_pc};

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (flush),
        .count      (count),
        .head       (head)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH_RUN;
        else     state <= state_next;
    end

    // Next state: a misaligned redirect parks the stage until reset.
    always_comb begin
        state_next = state;
        unique case (state)
            FETCH_RUN:   if (redir_bad) state_next = FETCH_FAULT;
            FETCH_FAULT: state_next = FETCH_FAULT;
        endcase
    end

    // PCs and in-flight counters; a redirect marks every in-flight response stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= in_flight_next;
            if (redir_ok) begin
                pc      <= redirect_pc;
                resp_pc <= redirect_pc;
                drop    <= in_flight_next;
            end else begin
                if (req_fire) pc <= pc + 32'd4;
                if (push)     resp_pc <= resp_pc + 32'd4;
                if (imem_resp_valid && (drop != '0)) drop <= drop - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model returns word = address,
// a scoreboard queue holds the PCs decode is expected to see.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fault;

    fetch_unit #(.RESET_PC(32'h100), .DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_del   = 0;
    int n_acc   = 0;
    int cyc     = 0;
    int lat     = 1;

    logic [31:0] exp_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] exp_req;

    logic        s_rv, s_iv, s_fault;
    logic [31:0] s_addr, s_inst, s_ipc, s_drop;

    typedef struct {
        logic        rv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] ipc;
    } vec_t;

    typedef struct {
        int          lat;
        int          at;
        logic [31:0] rpc;
        int          drop;
    } redir_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit rdy, input bit ird, input bit rdir,
                        input logic [31:0] rpc);
        @(negedge clk);
        s_rv    = imem_req_valid;
        s_addr  = imem_req_addr;
        s_iv    = inst_valid;
        s_inst  = inst;
        s_ipc   = inst_pc;
        s_fault = fault;
        s_drop  = 32'(dut.drop);
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = pend_addr.pop_front();
            void'(pend_due.pop_front());
        end
        imem_req_ready = rdy;
        inst_ready     = ird;
        redirect_valid = rdir;
        redirect_pc    = rpc;
        if (s_rv && rdy) begin
            chk("req_addr", s_addr, exp_req);
            pend_addr.push_back(s_addr);
            pend_due.push_back(cyc + lat);
            exp_req = exp_req + 32'd4;
            n_acc++;
        end
        if (!s_iv) chk("idle_inst_zero", s_inst | s_ipc, 32'h0);
        if (s_iv && ird && !rdir) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_delivery", s_ipc, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("deliver_pc", s_ipc, e);
                chk("deliver_inst", s_inst, e);
            end
            n_del++;
        end
        if (rdir && rpc[1:0] == 2'b00) begin
            exp_q.delete();
            for (int i = 0; i < 64; i++) exp_q.push_back(rpc + 32'(4 * i));
            exp_req = rpc;
        end
        cyc++;
    endtask

    task automatic do_reset(input bit check);
        @(negedge clk);
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        inst_ready      = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(32'h100 + 32'(4 * i));
        exp_req = 32'h100;
        cyc     = 0;
        #1;
        if (check) begin
            chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
            chk("rst_req_addr", imem_req_addr, 32'h100);
            chk("rst_inst_valid", 32'(inst_valid), 32'h0);
            chk("rst_inst", inst, 32'h0);
            chk("rst_inst_pc", inst_pc, 32'h0);
            chk("rst_fault", 32'(fault), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        if (check) chk("release_req_valid", 32'(imem_req_valid), 32'h1);
    endtask

    task automatic run_until(input int n, input int budget);
        int start;
        int k;
        start = n_del;
        k = 0;
        while ((n_del - start) < n && k < budget) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            k++;
        end
        chk("delivery_count", 32'(n_del - start), 32'(n));
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        rst = 1'b1;
        #1;
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
        chk({tag, "_req_addr"}, imem_req_addr, 32'h100);
        chk({tag, "_inst_valid"}, 32'(inst_valid), 32'h0);
        chk({tag, "_inst"}, inst, 32'h0);
        chk({tag, "_inst_pc"}, inst_pc, 32'h0);
        chk({tag, "_fault"}, 32'(fault), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t   tbl[7];
        redir_t rtbl[4];
        int     acc0;
        int     inflight;

        tbl[0] = '{1'b1, 32'h100, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 32'h104, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 32'h108, 1'b1, 32'h100};
        tbl[3] = '{1'b1, 32'h108, 1'b1, 32'h104};
        tbl[4] = '{1'b1, 32'h10c, 1'b0, 32'h0};
        tbl[5] = '{1'b0, 32'h110, 1'b1, 32'h108};
        tbl[6] = '{1'b1, 32'h110, 1'b1, 32'h10c};

        rtbl[0] = '{3, 2, 32'h200, 2};
        rtbl[1] = '{1, 1, 32'h40, 1};
        rtbl[2] = '{1, 2, 32'h40, 0};
        rtbl[3] = '{2, 1, 32'h300, 2};

        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        inst_ready      = 1'b0;

        // Reset values and cycle-exact startup stream, 1-cycle memory.
        lat = 1;
        do_reset(1'b1);
        foreach (tbl[i]) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            chk("tbl_req_valid", 32'(s_rv), 32'(tbl[i].rv));
            chk("tbl_req_addr", s_addr, tbl[i].addr);
            chk("tbl_inst_valid", 32'(s_iv), 32'(tbl[i].iv));
            chk("tbl_inst_pc", s_ipc, tbl[i].ipc);
        end
        run_until(4, 40);

        // Backpressure: decode stalls for 10 cycles.
        do_reset(1'b0);
        acc0 = n_acc;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            if (i >= 2) begin
                chk("bp_inst_valid", 32'(s_iv), 32'h1);
                chk("bp_inst_hold", s_inst, 32'h100);
            end
        end
        chk("bp_req_valid_low", 32'(s_rv), 32'h0);
        chk("bp_accept_count", 32'(n_acc - acc0), 32'h2);
        run_until(4, 40);

        // Redirects with assorted same-cycle accept/response/pop mixes.
        foreach (rtbl[r]) begin
            do_reset(1'b0);
            lat = rtbl[r].lat;
            for (int c = 0; c < rtbl[r].at; c++) step(1'b1, 1'b1, 1'b0, 32'h0);
            step(1'b1, 1'b1, 1'b1, rtbl[r].rpc);
            inflight = pend_addr.size();
            step(1'b1, 1'b1, 1'b0, 32'h0);
            chk("redir_drop", s_drop, 32'(rtbl[r].drop));
            chk("redir_drop_model", s_drop, 32'(inflight));
            chk("redir_req_valid", 32'(s_rv), 32'h1);
            chk("redir_req_addr", s_addr, rtbl[r].rpc);
            run_until(3, 60);
        end

        // Misaligned redirect enters a sticky fault.
        lat = 1;
        do_reset(1'b0);
        for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("pre_fault", 32'(s_fault), 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h202);
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            chk("fault_flag", 32'(s_fault), 32'h1);
            chk("fault_req_valid", 32'(s_rv), 32'h0);
            chk("fault_inst_valid", 32'(s_iv), 32'h0);
        end
        async_reset_check("fault_rst");

        // Asynchronous reset with the queue full, then restart.
        do_reset(1'b0);
        for (int c = 0; c < 6; c++) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("full_inst_valid", 32'(s_iv), 32'h1);
        chk("full_inst", s_inst, 32'h100);
        chk("full_count", 32'(dut.count), 32'h2);
        async_reset_check("full_rst");
        do_reset(1'b0);
        run_until(4, 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
